// File: rtl/tug_scorer_pkg.sv
// Shared tug-of-war game definitions: rope positions, winner codes, victory patterns.
package tug_scorer_pkg;

  localparam int unsigned LED_W = 7;
  localparam int unsigned POS_W = 3;

  localparam logic [POS_W-1:0] POS_CENTRE    = 3'd3;
  localparam logic [POS_W-1:0] POS_LEFT_WIN  = 3'd6;
  localparam logic [POS_W-1:0] POS_RIGHT_WIN = 3'd0;

  typedef enum logic [1:0] {
    WIN_NONE  = 2'b00,
    WIN_LEFT  = 2'b01,
    WIN_RIGHT = 2'b10
  } winner_e;

  localparam logic [LED_W-1:0] VIC_LEFT  = 7'b1110000;
  localparam logic [LED_W-1:0] VIC_RIGHT = 7'b0000111;

  // One-hot rope LED for a position
  function automatic logic [LED_W-1:0] pos_to_led(input logic [POS_W-1:0] pos);
    return LED_W'(1) << pos;
  endfunction

  function automatic logic [LED_W-1:0] vic_pattern(input winner_e w);
    case (w)
      WIN_LEFT:  return VIC_LEFT;
      WIN_RIGHT: return VIC_RIGHT;
      default:   return '0;
    endcase
  endfunction

endpackage

// File: rtl/tug_scorer_btn_sync_edge.sv
// Two-flop synchronizer plus rising-edge detector: one-cycle pulse per press.
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic pulse_c
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= level;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Decoded from flops only; the consumer registers its effect
  assign pulse_c = sync2_q & ~prev_q;

endmodule

// File: rtl/tug_scorer.sv
// Tug-of-war scoring stage: rope position, win detection and victory blink.
module tug_scorer
  import tug_scorer_pkg::*;
#(
  parameter int unsigned BLINK_CYCLES = 25_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic             btn_l,
  input  logic             btn_r,
  output logic [LED_W-1:0] score,
  output logic [LED_W-1:0] victory_led,
  output logic             game_over,
  output logic [1:0]       winner
);

  localparam int unsigned CNT_W = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_CYCLES - 1);

  logic p_l;
  logic p_r;

  btn_sync_edge u_sync_l (
    .clk     (clk),
    .rst_n   (rst_n),
    .level   (btn_l),
    .pulse_c (p_l)
  );

  btn_sync_edge u_sync_r (
    .clk     (clk),
    .rst_n   (rst_n),
    .level   (btn_r),
    .pulse_c (p_r)
  );

  logic [POS_W-1:0] pos_q,   pos_d;
  winner_e          win_q,   win_d;
  logic             over_q,  over_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             phase_q, phase_d;
  logic [LED_W-1:0] score_d;
  logic [LED_W-1:0] vic_d;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q       <= POS_CENTRE;
      win_q       <= WIN_NONE;
      over_q      <= 1'b0;
      cnt_q       <= '0;
      phase_q     <= 1'b0;
      score       <= pos_to_led(POS_CENTRE);
      victory_led <= '0;
    end else begin
      pos_q       <= pos_d;
      win_q       <= win_d;
      over_q      <= over_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      score       <= score_d;
      victory_led <= vic_d;
    end
  end

  // Next-state: clear beats blink, blink runs only after a win, else apply moves
  always_comb begin
    pos_d   = pos_q;
    win_d   = win_q;
    over_d  = over_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;

    if (clear) begin
      pos_d   = POS_CENTRE;
      win_d   = WIN_NONE;
      over_d  = 1'b0;
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (over_q) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (enable && (p_l ^ p_r)) begin
      if (p_l && (pos_q != POS_LEFT_WIN)) begin
        pos_d = pos_q + POS_W'(1);
      end else if (p_r && (pos_q != POS_RIGHT_WIN)) begin
        pos_d = pos_q - POS_W'(1);
      end

      if (pos_d == POS_LEFT_WIN) begin
        win_d   = WIN_LEFT;
        over_d  = 1'b1;
        cnt_d   = '0;
        phase_d = 1'b1;
      end else if (pos_d == POS_RIGHT_WIN) begin
        win_d   = WIN_RIGHT;
        over_d  = 1'b1;
        cnt_d   = '0;
        phase_d = 1'b1;
      end
    end

    score_d = pos_to_led(pos_d);
    vic_d   = (over_d && phase_d) ? vic_pattern(win_d) : '0;
  end

  assign game_over = over_q;
  assign winner    = win_q;

endmodule

// File: tb/tb_tug_scorer.sv
// Directed vector bench for tug_scorer with a short blink period.
module tb_tug_scorer;

  localparam logic [6:0] CEN = 7'b0001000;
  localparam logic [6:0] P6  = 7'b1000000;
  localparam logic [6:0] P5  = 7'b0100000;
  localparam logic [6:0] P4  = 7'b0010000;
  localparam logic [6:0] P2  = 7'b0000100;
  localparam logic [6:0] P1  = 7'b0000010;
  localparam logic [6:0] P0  = 7'b0000001;
  localparam logic [6:0] VL  = 7'b1110000;
  localparam logic [6:0] VR  = 7'b0000111;
  localparam logic [6:0] Z   = 7'b0000000;

  typedef struct {
    logic       l;
    logic       r;
    logic       en;
    logic       clr;
    logic [6:0] sc;
    logic [1:0] win;
    logic       go;
    logic [6:0] vic;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       enable = 1'b0;
  logic       btn_l = 1'b0;
  logic       btn_r = 1'b0;
  logic [6:0] score;
  logic [6:0] victory_led;
  logic       game_over;
  logic [1:0] winner;

  int n_vec = 0;
  int n_err = 0;
  vec_t tbl[$];

  tug_scorer #(.BLINK_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .enable      (enable),
    .btn_l       (btn_l),
    .btn_r       (btn_r),
    .score       (score),
    .victory_led (victory_led),
    .game_over   (game_over),
    .winner      (winner)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic l, logic r, logic en, logic clr,
                              logic [6:0] sc, logic [1:0] win, logic go, logic [6:0] vic);
    vec_t v;
    v.l = l; v.r = r; v.en = en; v.clr = clr;
    v.sc = sc; v.win = win; v.go = go; v.vic = vic;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive at the falling edge, then sample just after the next rising edge
  task automatic step(input logic l, input logic r, input logic en, input logic clr);
    @(negedge clk);
    btn_l = l; btn_r = r; enable = en; clear = clr;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outs();
    return 32'({score, winner, game_over, victory_led});
  endfunction

  initial begin
    // idle, then left held 10 cycles -> one move
    tbl.push_back(mk(0,0,1,0, CEN,2'b00,0,Z));
    tbl.push_back(mk(0,0,1,0, CEN,2'b00,0,Z));
    repeat (2) tbl.push_back(mk(1,0,1,0, CEN,2'b00,0,Z));
    repeat (8) tbl.push_back(mk(1,0,1,0, P4,2'b00,0,Z));
    repeat (2) tbl.push_back(mk(0,0,1,0, P4,2'b00,0,Z));
    repeat (2) tbl.push_back(mk(1,0,1,0, P4,2'b00,0,Z));
    repeat (2) tbl.push_back(mk(0,0,1,0, P5,2'b00,0,Z));
    // single-cycle press reaches the left win
    tbl.push_back(mk(1,0,1,0, P5,2'b00,0,Z));
    tbl.push_back(mk(0,0,1,0, P5,2'b00,0,Z));
    tbl.push_back(mk(0,0,1,0, P6,2'b01,1,VL));
    // blink with right presses ignored
    tbl.push_back(mk(0,1,1,0, P6,2'b01,1,VL));
    tbl.push_back(mk(0,0,1,0, P6,2'b01,1,VL));
    tbl.push_back(mk(0,0,1,0, P6,2'b01,1,VL));
    tbl.push_back(mk(0,0,1,0, P6,2'b01,1,Z));
    tbl.push_back(mk(0,1,1,0, P6,2'b01,1,Z));
    tbl.push_back(mk(0,0,1,0, P6,2'b01,1,Z));
    tbl.push_back(mk(0,0,1,0, P6,2'b01,1,Z));
    tbl.push_back(mk(0,0,1,0, P6,2'b01,1,VL));
    tbl.push_back(mk(0,0,1,1, CEN,2'b00,0,Z));
    tbl.push_back(mk(0,0,1,0, CEN,2'b00,0,Z));
    // simultaneous presses
    repeat (2) tbl.push_back(mk(1,1,1,0, CEN,2'b00,0,Z));
    repeat (2) tbl.push_back(mk(0,0,1,0, CEN,2'b00,0,Z));
    // presses while disabled are dropped
    repeat (3) tbl.push_back(mk(1,0,0,0, CEN,2'b00,0,Z));
    tbl.push_back(mk(1,0,1,0, CEN,2'b00,0,Z));
    repeat (2) tbl.push_back(mk(0,0,1,0, CEN,2'b00,0,Z));
    // clear on the move edge wins, held button gives no second pulse
    repeat (2) tbl.push_back(mk(1,0,1,0, CEN,2'b00,0,Z));
    tbl.push_back(mk(1,0,1,1, CEN,2'b00,0,Z));
    tbl.push_back(mk(1,0,1,0, CEN,2'b00,0,Z));
    tbl.push_back(mk(0,0,1,0, CEN,2'b00,0,Z));
    // right win then clear
    tbl.push_back(mk(0,1,1,0, CEN,2'b00,0,Z));
    tbl.push_back(mk(0,0,1,0, CEN,2'b00,0,Z));
    tbl.push_back(mk(0,0,1,0, P2,2'b00,0,Z));
    tbl.push_back(mk(0,1,1,0, P2,2'b00,0,Z));
    tbl.push_back(mk(0,0,1,0, P2,2'b00,0,Z));
    tbl.push_back(mk(0,0,1,0, P1,2'b00,0,Z));
    tbl.push_back(mk(0,1,1,0, P1,2'b00,0,Z));
    tbl.push_back(mk(0,0,1,0, P1,2'b00,0,Z));
    tbl.push_back(mk(0,0,1,0, P0,2'b10,1,VR));
    tbl.push_back(mk(0,0,1,0, P0,2'b10,1,VR));
    tbl.push_back(mk(0,0,1,1, CEN,2'b00,0,Z));
    tbl.push_back(mk(0,0,1,0, CEN,2'b00,0,Z));

    #12;
    check("reset_state", outs(), 32'({CEN, 2'b00, 1'b0, Z}));
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].l, tbl[i].r, tbl[i].en, tbl[i].clr);
      check($sformatf("vec%0d", i), outs(),
            32'({tbl[i].sc, tbl[i].win, tbl[i].go, tbl[i].vic}));
    end

    // Right win, then async reset in the middle of the blink-off phase
    repeat (3) begin
      step(0,1,1,0);
      step(0,0,1,0);
      step(0,0,1,0);
    end
    check("rwin_score", 32'(score), 32'(P0));
    check("rwin_vic", 32'(victory_led), 32'(VR));
    repeat (5) step(0,0,1,0);
    check("blink_off", 32'({winner, game_over, victory_led}), 32'({2'b10, 1'b1, Z}));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_score", 32'(score), 32'(CEN));
    check("async_rst_winner", 32'(winner), 32'(2'b00));
    check("async_rst_over", 32'(game_over), 32'(1'b0));
    check("async_rst_vic", 32'(victory_led), 32'(Z));
    @(negedge clk);
    rst_n = 1'b1;
    step(0,1,1,0);
    step(0,0,1,0);
    check("post_rst_wait", 32'(score), 32'(CEN));
    step(0,0,1,0);
    check("post_rst_press", 32'({score, winner, game_over}), 32'({P2, 2'b00, 1'b0}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
